pcm_playout_ctr: RTL and testbench

PCM_PLAYOUT_CTR -- requirements
Module: pcm_playout_ctr

---
 rtl/pcm_playout_ctr.sv | 178 +++++++++++++++++
 tb/tb_pcm_playout_ctr.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pcm_playout_ctr.sv
`timescale 1ns/1ps
// pcm_playout_ctr
// Reads one PCM frame per frame-rate tick out of a ring buffer, one channel per
// bit clock. Each complete frame is presented as a single wide word with a
// one-cycle valid pulse. If the buffer is empty when the tick arrives, an
// underrun frame is presented instead and counted.
//
// Ports:
//   BIT_CLOCK_I            sole clock, rising edge
//   AC97_RESETN_I          asynchronous active-low reset
//   SAMPLE_FREQUENCY_I     selects DIV0..DIV3 bit clocks per frame
//   PCM_READ_ADVANCE_EN_I  allow the read pointer to step after a frame
//   PCM_WRITE_ADDRESS_I    producer pointer (next frame to be written)
//   PCM_READ_ADDRESS_O     frame address being played
//   PCM_READ_CH_O          channel index of the current buffer read
//   PCM_DATA_I             buffer data for the address/channel issued on the previous edge
//   FRAME_VALID_O          one-cycle pulse, new frame on FRAME_DATA_O
//   FRAME_DATA_O           channel c in bits [c*SAMPLE_W +: SAMPLE_W]
//   UNDERRUN_O             pulse alongside FRAME_VALID_O for an underrun frame
//   UNDERRUN_COUNT_O       saturating count of underrun frames
//
// Build option: define PCM_UNDERRUN_REPEAT_EN to make an underrun frame repeat
// the previous FRAME_DATA_O; by default an underrun frame is all zeros.
//
// Parameters must satisfy NUM_CH+2 < min(DIV0..DIV3), so a frame fetch always
// finishes before the next tick.
module pcm_playout_ctr #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 9,
  parameter int DIV0     = 256,
  parameter int DIV1     = 279,
  parameter int DIV2     = 384,
  parameter int DIV3     = 512
) (
  input  logic                         BIT_CLOCK_I,
  input  logic                         AC97_RESETN_I,
  input  logic [1:0]                   SAMPLE_FREQUENCY_I,
  input  logic                         PCM_READ_ADVANCE_EN_I,
  input  logic [ADDR_W-1:0]            PCM_WRITE_ADDRESS_I,
  output logic [ADDR_W-1:0]            PCM_READ_ADDRESS_O,
  output logic [2:0]                   PCM_READ_CH_O,
  input  logic [SAMPLE_W-1:0]          PCM_DATA_I,
  output logic                         FRAME_VALID_O,
  output logic [NUM_CH*SAMPLE_W-1:0]   FRAME_DATA_O,
  output logic                         UNDERRUN_O,
  output logic [15:0]                  UNDERRUN_COUNT_O
);

  typedef enum logic [1:0] {IDLE, FETCH, LAST, PRESENT} state_t;

  state_t                       state, next_state;
  logic [15:0]                  div_cnt;
  logic [15:0]                  div_len;
  logic [15:0]                  sel_len;
  logic                         tick;
  logic                         empty;
  logic                         underrun_frame;
  logic [NUM_CH*SAMPLE_W-1:0]   stage;

  // ---------------------------------------------------------------------------
  // Frame-rate divider. The period length is only re-sampled at the wrap, so a
  // rate change mid-period never produces a short or long frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no
    // path can leave it unassigned and infer a latch.
    sel_len = 16'(DIV0);
    case (SAMPLE_FREQUENCY_I)
      2'd1:    sel_len = 16'(DIV1);
      2'd2:    sel_len = 16'(DIV2);
      2'd3:    sel_len = 16'(DIV3);
      default: sel_len = 16'(DIV0);
    endcase
  end

  // Counter is 0 straight out of reset, so the first tick lands on the first
  // rising edge after release.
  assign tick  = (div_cnt == 16'd0);
  assign empty = (PCM_READ_ADDRESS_O == PCM_WRITE_ADDRESS_I);

  always_ff @(posedge BIT_CLOCK_I or negedge AC97_RESETN_I) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!AC97_RESETN_I) begin
      div_cnt <= 16'd0;
      div_len <= 16'(DIV0);
    end else if (div_cnt == div_len - 16'd1) begin
      div_cnt <= 16'd0;
      div_len <= sel_len;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM. Ticks outside IDLE are simply not looked at.
  // ---------------------------------------------------------------------------
  always_ff @(posedge BIT_CLOCK_I or negedge AC97_RESETN_I) begin
    if (!AC97_RESETN_I) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (tick) begin
          if (empty)            next_state = PRESENT;
          else if (NUM_CH == 1) next_state = LAST;
          else                  next_state = FETCH;
        end
      end
      // Leaves once the channel about to be issued is the final one.
      FETCH:   if (PCM_READ_CH_O == 3'(NUM_CH - 2)) next_state = LAST;
      LAST:    next_state = PRESENT;
      PRESENT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: channel issue, staging capture, frame presentation, pointers.
  // Data captured on an edge belongs to the channel issued on the edge before.
  // ---------------------------------------------------------------------------
  always_ff @(posedge BIT_CLOCK_I or negedge AC97_RESETN_I) begin
    if (!AC97_RESETN_I) begin
      // NOTE: the staging register is small and must read as zero after reset,
      // so it is reset like any other flop rather than treated as memory.
      PCM_READ_ADDRESS_O <= '0;
      PCM_READ_CH_O      <= 3'd0;
      FRAME_VALID_O      <= 1'b0;
      FRAME_DATA_O       <= '0;
      UNDERRUN_O         <= 1'b0;
      UNDERRUN_COUNT_O   <= 16'd0;
      underrun_frame     <= 1'b0;
      stage              <= '0;
    end else begin
      FRAME_VALID_O <= 1'b0;
      UNDERRUN_O    <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            PCM_READ_CH_O  <= 3'd0;
            underrun_frame <= empty;
          end
        end
        FETCH: begin
          stage[int'(PCM_READ_CH_O)*SAMPLE_W +: SAMPLE_W] <= PCM_DATA_I;
          PCM_READ_CH_O <= PCM_READ_CH_O + 3'd1;
        end
        LAST: begin
          stage[(NUM_CH-1)*SAMPLE_W +: SAMPLE_W] <= PCM_DATA_I;
          PCM_READ_CH_O <= 3'd0;
        end
        PRESENT: begin
          FRAME_VALID_O <= 1'b1;
          if (underrun_frame) begin
            UNDERRUN_O <= 1'b1;
            if (UNDERRUN_COUNT_O != 16'hFFFF)
              UNDERRUN_COUNT_O <= UNDERRUN_COUNT_O + 16'd1;
`ifdef PCM_UNDERRUN_REPEAT_EN
            // Previous frame stays on FRAME_DATA_O untouched.
`else
            FRAME_DATA_O <= '0;
`endif
          end else begin
            FRAME_DATA_O <= stage;
            if (PCM_READ_ADVANCE_EN_I)
              PCM_READ_ADDRESS_O <= PCM_READ_ADDRESS_O + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_playout_ctr.sv
`timescale 1ns/1ps
// Directed testbench for pcm_playout_ctr (NUM_CH=2, SAMPLE_W=16, ADDR_W=9,
// DIV3 shortened to 16 so a full address wrap fits in a short run).
module tb_pcm_playout_ctr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  freq;
  logic        adv;
  logic [8:0]  wr_addr;
  logic [8:0]  rd_addr;
  logic [2:0]  rd_ch;
  logic [15:0] pcm_data;
  logic        frame_valid;
  logic [31:0] frame_data;
  logic        underrun;
  logic [15:0] ucount;

  int errors = 0;
  int checks = 0;
  logic [8:0]  exp_addr;
  logic [31:0] prev_frame;
  int          e;

  always #5 clk = ~clk;

  pcm_playout_ctr #(
    .NUM_CH(2), .SAMPLE_W(16), .ADDR_W(9),
    .DIV0(256), .DIV1(279), .DIV2(384), .DIV3(16)
  ) dut (
    .BIT_CLOCK_I           (clk),
    .AC97_RESETN_I         (rst_n),
    .SAMPLE_FREQUENCY_I    (freq),
    .PCM_READ_ADVANCE_EN_I (adv),
    .PCM_WRITE_ADDRESS_I   (wr_addr),
    .PCM_READ_ADDRESS_O    (rd_addr),
    .PCM_READ_CH_O         (rd_ch),
    .PCM_DATA_I            (pcm_data),
    .FRAME_VALID_O         (frame_valid),
    .FRAME_DATA_O          (frame_data),
    .UNDERRUN_O            (underrun),
    .UNDERRUN_COUNT_O      (ucount)
  );

  // Buffer content model: address 5 holds the hand-picked pair, everything
  // else is a pattern unique per address and channel.
  function automatic logic [15:0] pat(input logic [8:0] a, input logic [2:0] c);
    if (a == 9'd5) return (c == 3'd0) ? 16'h1234 : 16'hABCD;
    return {c[0], 3'b101, 3'b000, a};
  endfunction

  function automatic logic [31:0] exp_frame(input logic [8:0] a);
    return {pat(a, 3'd1), pat(a, 3'd0)};
  endfunction

  // Buffer answers the address/channel in time for the next edge.
  assign pcm_data = pat(rd_addr, rd_ch);

  // Counts rising edges until FRAME_VALID_O is seen 1ns after an edge;
  // returns 0 if none appears within the limit.
  task automatic wait_frame(input int limit, output int edges);
    edges = 0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      if (frame_valid) begin
        edges = k + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; freq = 2'd0; adv = 1'b1; wr_addr = 9'h100;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_addr !== 9'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", rd_addr); end
    checks++; if (rd_ch !== 3'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", rd_ch); end
    checks++; if (frame_valid !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL reset_pulses valid=%b underrun=%b exp=0", frame_valid, underrun); end
    checks++; if (frame_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", frame_data); end
    checks++; if (ucount !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ucount); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = 9'd0;
  endtask

  task automatic test_first_frame();
    // First tick on edge 0 after release, frame visible after edge 3.
    wait_frame(20, e);
    checks++; if (e !== 4) begin errors++; $display("FAIL first_latency got=%0d exp=4", e); end
    checks++; if (frame_data !== exp_frame(9'd0)) begin errors++; $display("FAIL first_data got=%h exp=%h", frame_data, exp_frame(9'd0)); end
    checks++; if (rd_addr !== 9'd1 || underrun !== 1'b0) begin errors++; $display("FAIL first_addr got=%h un=%b exp=001 un=0", rd_addr, underrun); end
    @(posedge clk); #1;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width got=%b exp=0", frame_valid); end
    wait_frame(300, e);
    checks++; if (e !== 255) begin errors++; $display("FAIL period_256 got=%0d exp=255", e + 0); end
    checks++; if (frame_data !== exp_frame(9'd1) || rd_addr !== 9'd2) begin errors++; $display("FAIL second_frame data=%h addr=%h exp=%h 002", frame_data, rd_addr, exp_frame(9'd1)); end
    exp_addr = 9'd2;
  endtask

  task automatic test_data_lanes();
    while (exp_addr != 9'd5) begin
      wait_frame(300, e);
      checks++; if (e !== 256 || frame_data !== exp_frame(exp_addr)) begin errors++; $display("FAIL walk_frame addr=%h edges=%0d data=%h exp=%h", exp_addr, e, frame_data, exp_frame(exp_addr)); end
      exp_addr = exp_addr + 9'd1;
    end
    wait_frame(300, e);
    checks++; if (frame_data !== 32'hABCD1234) begin errors++; $display("FAIL lane_order got=%h exp=abcd1234", frame_data); end
    checks++; if (rd_addr !== 9'd6) begin errors++; $display("FAIL lane_addr got=%h exp=006", rd_addr); end
    exp_addr = 9'd6;
  endtask

  task automatic test_hold();
    adv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_frame(300, e);
      checks++; if (frame_data !== exp_frame(9'd6) || rd_addr !== 9'd6 || underrun !== 1'b0) begin
        errors++; $display("FAIL hold_frame%0d data=%h addr=%h un=%b exp=%h 006 0", i, frame_data, rd_addr, underrun, exp_frame(9'd6));
      end
    end
    adv = 1'b1;
  endtask

  task automatic test_freq_switch();
    freq = 2'd2;
    wait_frame(500, e);
    checks++; if (e !== 256 || frame_data !== exp_frame(exp_addr)) begin errors++; $display("FAIL switch_current edges=%0d data=%h exp=256 %h", e, frame_data, exp_frame(exp_addr)); end
    exp_addr = exp_addr + 9'd1;
    wait_frame(500, e);
    checks++; if (e !== 384) begin errors++; $display("FAIL switch_next got=%0d exp=384", e); end
    exp_addr = exp_addr + 9'd1;
    freq = 2'd3;
    wait_frame(500, e);
    checks++; if (e !== 384) begin errors++; $display("FAIL switch_hold384 got=%0d exp=384", e); end
    exp_addr = exp_addr + 9'd1;
    wait_frame(500, e);
    checks++; if (e !== 16 || frame_data !== exp_frame(exp_addr)) begin errors++; $display("FAIL switch_16 edges=%0d data=%h exp=16 %h", e, frame_data, exp_frame(exp_addr)); end
    exp_addr = exp_addr + 9'd1;
  endtask

  task automatic test_wrap_underrun();
    wr_addr = 9'h000;
    while (exp_addr != 9'd0) begin
      wait_frame(40, e);
      checks++; if (e !== 16 || frame_data !== exp_frame(exp_addr) || rd_addr !== exp_addr + 9'd1) begin
        errors++; $display("FAIL wrap_walk addr=%h edges=%0d data=%h rd=%h exp=%h", exp_addr, e, frame_data, rd_addr, exp_frame(exp_addr));
        if (e == 0) break;
      end
      exp_addr = exp_addr + 9'd1;
    end
    checks++; if (rd_addr !== 9'h000 || frame_data !== exp_frame(9'h1FF)) begin errors++; $display("FAIL wrap_1ff rd=%h data=%h exp=000 %h", rd_addr, frame_data, exp_frame(9'h1FF)); end
    prev_frame = exp_frame(9'h1FF);
    // Underrun frame appears one edge after its tick: 13 + 1 edges later.
    wait_frame(40, e);
    checks++; if (e !== 14) begin errors++; $display("FAIL underrun_latency got=%0d exp=14", e); end
    checks++; if (underrun !== 1'b1 || ucount !== 16'd1) begin errors++; $display("FAIL underrun_first un=%b cnt=%0d exp=1 1", underrun, ucount); end
`ifdef PCM_UNDERRUN_REPEAT_EN
    checks++; if (frame_data !== prev_frame) begin errors++; $display("FAIL underrun_data got=%h exp=%h", frame_data, prev_frame); end
`else
    checks++; if (frame_data !== 32'd0) begin errors++; $display("FAIL underrun_data got=%h exp=0", frame_data); end
`endif
    checks++; if (rd_addr !== 9'h000) begin errors++; $display("FAIL underrun_addr got=%h exp=000", rd_addr); end
    @(posedge clk); #1;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pulse_width got=%b exp=0", underrun); end
    wait_frame(40, e);
    checks++; if (e !== 15 || underrun !== 1'b1 || ucount !== 16'd2) begin errors++; $display("FAIL underrun_second edges=%0d un=%b cnt=%0d exp=15 1 2", e, underrun, ucount); end
  endtask

  task automatic test_reset_mid_fetch();
    wr_addr = 9'h010;
    // Normal frame 16 edges after the underrun tick, plus three of latency.
    wait_frame(40, e);
    checks++; if (e !== 18 || frame_data !== exp_frame(9'd0) || rd_addr !== 9'd1) begin
      errors++; $display("FAIL refill edges=%0d data=%h rd=%h exp=18 %h 001", e, frame_data, rd_addr, exp_frame(9'd0));
    end
    // Next tick is 13 edges after this frame; stop just after it, in FETCH.
    repeat (13) @(posedge clk);
    #1;
    checks++; if (rd_ch !== 3'd0 || frame_valid !== 1'b0) begin errors++; $display("FAIL fetch_state ch=%0d valid=%b exp=0 0", rd_ch, frame_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rd_addr !== 9'd0 || frame_data !== 32'd0 || ucount !== 16'd0 || frame_valid !== 1'b0 || underrun !== 1'b0 || rd_ch !== 3'd0) begin
      errors++; $display("FAIL midfetch_reset rd=%h data=%h cnt=%0d valid=%b un=%b ch=%0d exp all 0", rd_addr, frame_data, ucount, frame_valid, underrun, rd_ch);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL abandoned_frame valid=%b exp=0", frame_valid); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame(20, e);
    checks++; if (e !== 4 || frame_data !== exp_frame(9'd0) || rd_addr !== 9'd1) begin
      errors++; $display("FAIL after_release edges=%0d data=%h rd=%h exp=4 %h 001", e, frame_data, rd_addr, exp_frame(9'd0));
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_data_lanes();
    test_hold();
    test_freq_switch();
    test_wrap_underrun();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
